// File: rtl/debug_mem_sequencer_if.sv
// rtl/debug_mem_sequencer_if.sv - command/response channel bundle for the debug memory sequencer
// Ports (signals):
//   cmd_valid/cmd_ready/cmd_write/cmd_addr[15:0]/cmd_wdata[31:0] : host command channel
//   rsp_valid/rsp_ready/rsp_rdata[31:0]                          : sequencer response channel
// Modports: master = debug host, slave = sequencer.
interface debug_mem_sequencer_if;
  logic        cmd_valid;
  logic        cmd_ready;
  logic        cmd_write;
  logic [15:0] cmd_addr;
  logic [31:0] cmd_wdata;
  logic        rsp_valid;
  logic        rsp_ready;
  logic [31:0] rsp_rdata;

  modport master (
    output cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    input  cmd_ready, rsp_valid, rsp_rdata
  );

  modport slave (
    input  cmd_valid, cmd_write, cmd_addr, cmd_wdata, rsp_ready,
    output cmd_ready, rsp_valid, rsp_rdata
  );
endinterface

// File: rtl/debug_mem_sequencer.sv
// rtl/debug_mem_sequencer.sv - debug host access sequencer for a CPU-shared SRAM wrapper
// Ports:
//   clk, resetn (async, active-low)
//   session_req in / session_active out  : debug ownership request and grant
//   cpu_hold out / cpu_halted in         : CPU stop handshake
//   halt_err out                         : sticky halt timeout flag
//   bus (debug_mem_sequencer_if.slave)   : command and response channels
//   access_bits_in[55:0] out             : wrapper control ([55] en, [49] write, [48] trigger, [47:32] word addr, [31:0] wdata)
//   access_bits_out[55:0] in             : wrapper return ([31:0] read data)
// Build option: DBG_SEQ_AUTOINC_EN makes cmd_addr 16'hFFFF mean "previous word address + 1".
module debug_mem_sequencer #(
  parameter int ADDR_WIDTH   = 8,
  parameter int TRIG_CYCLES  = 4,
  parameter int HALT_TIMEOUT = 255
) (
  input  logic                 clk,
  input  logic                 resetn,
  input  logic                 session_req,
  output logic                 cpu_hold,
  input  logic                 cpu_halted,
  output logic                 session_active,
  output logic                 halt_err,
  debug_mem_sequencer_if.slave bus,
  output logic [55:0]          access_bits_in,
  input  logic [55:0]          access_bits_out
);

  localparam int WW = ADDR_WIDTH - 2;

  typedef enum logic [2:0] {
    S_IDLE, S_HALT_WAIT, S_READY, S_TRIG, S_RECOVER, S_RESP, S_RELEASE
  } state_t;

  state_t          state_q, state_d;
  logic [15:0]     cnt_q, cnt_d;
  logic            req_prev_q, req_prev_d;
  logic            halt_err_q, halt_err_d;
  logic            acc_write_q, acc_write_d;
  logic [15:0]     acc_addr_q, acc_addr_d;
  logic [31:0]     acc_wdata_q, acc_wdata_d;
  logic [WW-1:0]   last_waddr_q, last_waddr_d;
  logic [31:0]     rsp_rdata_q, rsp_rdata_d;
  logic            cpu_hold_q, cpu_hold_d;
  logic            session_active_q, session_active_d;
  logic            cmd_ready_q, cmd_ready_d;
  logic            rsp_valid_q, rsp_valid_d;
  logic            access_en_q, access_en_d;
  logic            trigger_q, trigger_d;
  logic [WW-1:0]   cmd_waddr;
  logic            unused_inputs;

  assign unused_inputs = ^{access_bits_out[55:32], bus.cmd_addr};

`ifdef DBG_SEQ_AUTOINC_EN
  assign cmd_waddr = (bus.cmd_addr == 16'hFFFF) ? last_waddr_q + WW'(1)
                                                 : bus.cmd_addr[ADDR_WIDTH-1:2];
`else
  assign cmd_waddr = bus.cmd_addr[ADDR_WIDTH-1:2];
`endif

  // State and registered outputs.
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      state_q          <= S_IDLE;
      cnt_q            <= '0;
      req_prev_q       <= 1'b0;
      halt_err_q       <= 1'b0;
      acc_write_q      <= 1'b0;
      acc_addr_q       <= '0;
      acc_wdata_q      <= '0;
      last_waddr_q     <= '0;
      rsp_rdata_q      <= '0;
      cpu_hold_q       <= 1'b0;
      session_active_q <= 1'b0;
      cmd_ready_q      <= 1'b0;
      rsp_valid_q      <= 1'b0;
      access_en_q      <= 1'b0;
      trigger_q        <= 1'b0;
    end else begin
      state_q          <= state_d;
      cnt_q            <= cnt_d;
      req_prev_q       <= req_prev_d;
      halt_err_q       <= halt_err_d;
      acc_write_q      <= acc_write_d;
      acc_addr_q       <= acc_addr_d;
      acc_wdata_q      <= acc_wdata_d;
      last_waddr_q     <= last_waddr_d;
      rsp_rdata_q      <= rsp_rdata_d;
      cpu_hold_q       <= cpu_hold_d;
      session_active_q <= session_active_d;
      cmd_ready_q      <= cmd_ready_d;
      rsp_valid_q      <= rsp_valid_d;
      access_en_q      <= access_en_d;
      trigger_q        <= trigger_d;
    end
  end

  // Next state, phase counter and datapath captures.
  always_comb begin
    state_d      = state_q;
    cnt_d        = cnt_q;
    req_prev_d   = session_req;
    halt_err_d   = halt_err_q;
    acc_write_d  = acc_write_q;
    acc_addr_d   = acc_addr_q;
    acc_wdata_d  = acc_wdata_q;
    last_waddr_d = last_waddr_q;
    rsp_rdata_d  = rsp_rdata_q;

    unique case (state_q)
      S_IDLE: begin
        cnt_d = '0;
        if (session_req) begin
          state_d = S_HALT_WAIT;
          // Only a fresh request acknowledges a previous halt failure.
          if (!req_prev_q) halt_err_d = 1'b0;
        end
      end
      S_HALT_WAIT: begin
        if (cpu_halted) begin
          state_d = S_READY;
          cnt_d   = '0;
        end else if (cnt_q == 16'(HALT_TIMEOUT - 1)) begin
          state_d    = S_IDLE;
          halt_err_d = 1'b1;
          cnt_d      = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_READY: begin
        // cmd_ready is high exactly while in READY, so valid alone completes the handshake.
        if (bus.cmd_valid) begin
          state_d      = S_TRIG;
          cnt_d        = '0;
          acc_write_d  = bus.cmd_write;
          acc_addr_d   = 16'(cmd_waddr);
          acc_wdata_d  = bus.cmd_wdata;
          last_waddr_d = cmd_waddr;
        end else if (!session_req) begin
          state_d = S_RELEASE;
        end
      end
      S_TRIG: begin
        if (cnt_q == 16'(TRIG_CYCLES - 1)) begin
          state_d     = S_RECOVER;
          cnt_d       = '0;
          rsp_rdata_d = acc_write_q ? acc_wdata_q : access_bits_out[31:0];
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RECOVER: begin
        if (cnt_q == 16'd1) begin
          state_d = S_RESP;
          cnt_d   = '0;
        end else begin
          cnt_d = cnt_q + 16'd1;
        end
      end
      S_RESP: begin
        // A request dropped mid-access takes effect only once the response is taken.
        if (bus.rsp_ready) state_d = session_req ? S_READY : S_RELEASE;
      end
      S_RELEASE: begin
        state_d = S_IDLE;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase

    if (state_d == S_IDLE) begin
      acc_write_d = 1'b0;
      acc_addr_d  = '0;
      acc_wdata_d = '0;
    end
  end

  // Output values registered alongside the state they belong to.
  always_comb begin
    cpu_hold_d       = (state_d != S_IDLE);
    session_active_d = state_d inside {S_READY, S_TRIG, S_RECOVER, S_RESP, S_RELEASE};
    access_en_d      = state_d inside {S_READY, S_TRIG, S_RECOVER, S_RESP};
    trigger_d        = (state_d == S_TRIG);
    cmd_ready_d      = (state_d == S_READY);
    rsp_valid_d      = (state_d == S_RESP);
  end

  assign cpu_hold       = cpu_hold_q;
  assign session_active = session_active_q;
  assign halt_err       = halt_err_q;
  assign bus.cmd_ready  = cmd_ready_q;
  assign bus.rsp_valid  = rsp_valid_q;
  assign bus.rsp_rdata  = rsp_rdata_q;
  assign access_bits_in = {access_en_q, 5'b00000, acc_write_q, trigger_q, acc_addr_q, acc_wdata_q};

endmodule
